// File: rtl/cache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_ctrl_pkg
//   Shared definitions for the cache control merge/select handshake blocks.
//   Contents:
//     NBR       - number of upstream branches joined by a merge
//     state_t   - merge FSM states (idle, delay countdown, wait for free)
//     rr_pick4  - round-robin pick over a 4-bit pending vector
// ---------------------------------------------------------------------------
package cache_ctrl_pkg;

  localparam int NBR = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DELAY     = 2'd1,
    ST_WAIT_FREE = 2'd2
  } state_t;

  // Scan last+1, last+2, last+3, last (mod 4) and return the first pending
  // index. The loop runs backwards so the nearest candidate overwrites the
  // farther ones. With nothing pending the result is just `last`, which the
  // caller ignores because it only loads a grant when pend is non-zero.
  function automatic logic [1:0] rr_pick4(input logic [3:0] pend,
                                          input logic [1:0] last);
    logic [1:0] idx;
    rr_pick4 = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (pend[idx]) rr_pick4 = idx;
    end
  endfunction

endpackage

// File: rtl/c_rr_arb4.sv
// ---------------------------------------------------------------------------
// c_rr_arb4
//   Round-robin pick for four requesters plus the register holding the most
//   recent winner. The pick is purely combinational; `last` only moves when
//   the owner accepts the pick.
// Ports:
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous active-low reset (last returns to 3)
//   pend    in   4  pending request vector
//   update  in   1  pick is being granted this cycle, remember it
//   pick    out  2  index of the next winner after `last`
// ---------------------------------------------------------------------------
module c_rr_arb4
  import cache_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [NBR-1:0] pend,
  input  logic           update,
  output logic [1:0]     pick
);

  logic [1:0] last;

  assign pick = rr_pick4(pend, last);

  // Last starts at 3 so branch 0 is the first winner out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last <= 2'd3;
    end else if (update) begin
      last <= pick;
    end
  end

endmodule

// File: rtl/c_merge4_cache.sv
// ---------------------------------------------------------------------------
// c_merge4_cache
//   4-to-1 merge for the cache control drive/free handshake. Tokens from four
//   lookup branches are latched as pending, granted one at a time in
//   round-robin order, forwarded downstream DELAY cycles after the grant, and
//   the winning branch gets a free pulse once downstream frees the token.
// Parameters:
//   DELAY        cycles from o_fire to o_driveNext, legal range 1..15
// Ports:
//   clk          in   1  rising-edge clock
//   rst          in   1  synchronous active-low reset
//   i_drive      in   4  one-cycle token pulse per branch
//   o_free       out  4  one-cycle pulse: branch token consumed downstream
//   o_fire       out  1  one-cycle pulse: a token was granted
//   o_sel        out  2  current grant index, held until the free pulse
//   o_grant      out  4  one-hot grant while busy, 0 when idle
//   o_driveNext  out  1  one-cycle drive pulse to downstream
//   i_freeNext   in   1  one-cycle pulse from downstream: token consumed
//   o_busy       out  1  high from o_fire through the wait for free
//   o_overflow   out  1  sticky: a token arrived on an already-pending branch
// ---------------------------------------------------------------------------
module c_merge4_cache
  import cache_ctrl_pkg::*;
#(
  parameter int DELAY = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NBR-1:0] i_drive,
  output logic [NBR-1:0] o_free,
  output logic           o_fire,
  output logic [1:0]     o_sel,
  output logic [NBR-1:0] o_grant,
  output logic           o_driveNext,
  input  logic           i_freeNext,
  output logic           o_busy,
  output logic           o_overflow
);

  state_t         state;
  logic [3:0]     cnt;
  logic [NBR-1:0] pend;
  logic [NBR-1:0] pend_clr;
  logic [1:0]     pick;
  logic           take;

  // A grant is taken whenever the merge is idle with anything pending.
  assign take = (state == ST_IDLE) && (|pend);

  // The granted branch is released in the same cycle that its free pulse is
  // registered, so the clear mask is the live one-hot grant.
  assign pend_clr = (state == ST_WAIT_FREE && i_freeNext) ? o_grant : '0;

  c_rr_arb4 u_arb (
    .clk    (clk),
    .rst    (rst),
    .pend   (pend),
    .update (take),
    .pick   (pick)
  );

  // Pending latches. A new token beats a simultaneous release so a branch
  // that re-drives right as it is freed is not lost. A token landing on a
  // branch that stays pending is dropped and flagged as overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend       <= '0;
      o_overflow <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) | i_drive;
      if (|(i_drive & pend & ~pend_clr)) begin
        o_overflow <= 1'b1;
      end
    end
  end

  // Merge FSM. All handshake outputs are registered; pulses default low and
  // are raised for one cycle on the relevant transition. Downstream frees are
  // only honoured while waiting for one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      o_fire      <= 1'b0;
      o_sel       <= 2'd0;
      o_grant     <= '0;
      o_busy      <= 1'b0;
      o_driveNext <= 1'b0;
      o_free      <= '0;
    end else begin
      o_fire      <= 1'b0;
      o_driveNext <= 1'b0;
      o_free      <= '0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            state   <= ST_DELAY;
            o_fire  <= 1'b1;
            o_sel   <= pick;
            o_grant <= 4'b0001 << pick;
            o_busy  <= 1'b1;
            cnt     <= 4'(DELAY - 1);
          end
        end
        ST_DELAY: begin
          if (cnt == 4'd0) begin
            state       <= ST_WAIT_FREE;
            o_driveNext <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WAIT_FREE: begin
          if (i_freeNext) begin
            state   <= ST_IDLE;
            o_free  <= o_grant;
            o_grant <= '0;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c_merge4_cache.sv
// ---------------------------------------------------------------------------
// tb_c_merge4_cache
//   Directed bench for c_merge4_cache. Instance u_a uses the default DELAY=4,
//   instance u_b uses DELAY=1. Inputs are changed 1ns after a rising edge and
//   outputs are read at the same point, so "cycle n" means the interval after
//   rising edge n.
// ---------------------------------------------------------------------------
module tb_c_merge4_cache;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] drive_a, drive_b;
  logic       free_next_a, free_next_b;
  logic [3:0] free_a, free_b, grant_a, grant_b;
  logic [1:0] sel_a, sel_b;
  logic       fire_a, fire_b, dn_a, dn_b, busy_a, busy_b, ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c_merge4_cache #(.DELAY(4)) u_a (
    .clk(clk), .rst(rst), .i_drive(drive_a), .o_free(free_a), .o_fire(fire_a),
    .o_sel(sel_a), .o_grant(grant_a), .o_driveNext(dn_a), .i_freeNext(free_next_a),
    .o_busy(busy_a), .o_overflow(ovf_a)
  );

  c_merge4_cache #(.DELAY(1)) u_b (
    .clk(clk), .rst(rst), .i_drive(drive_b), .o_free(free_b), .o_fire(fire_b),
    .o_sel(sel_b), .o_grant(grant_b), .o_driveNext(dn_b), .i_freeNext(free_next_b),
    .o_busy(busy_b), .o_overflow(ovf_b)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with all inputs idle, then release it.
  task automatic do_reset();
    rst = 1'b0;
    drive_a = '0; drive_b = '0; free_next_a = 1'b0; free_next_b = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Reset with tokens being driven: every output clear, nothing left pending.
  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b0;
    drive_a = 4'b1111; drive_b = 4'b1111; free_next_a = 1'b0; free_next_b = 1'b0;
    step();
    step();
    checks++; if (free_a !== 4'b0) begin errors++; $display("[TB] FAIL reset_free: got %b expected 0000", free_a); end
    checks++; if (fire_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_fire: got %b expected 0", fire_a); end
    checks++; if (sel_a !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel: got %0d expected 0", sel_a); end
    checks++; if (grant_a !== 4'b0) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant_a); end
    checks++; if (dn_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_driveNext: got %b expected 0", dn_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", ovf_a); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_b: got %b expected 0", busy_b); end
    rst = 1'b1;
    drive_a = '0; drive_b = '0;
    step();
    step();
    checks++; if (fire_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_pend: got fire %b expected 0", fire_a); end
  endtask

  // Single token on branch 2 through the whole handshake with DELAY=4.
  task automatic test_single();
    logic exp_dn;
    $display("[TB] test_single");
    do_reset();
    drive_a = 4'b0100;
    step();
    drive_a = '0;
    checks++; if (fire_a !== 1'b0) begin errors++; $display("[TB] FAIL single_fire_early: got %b expected 0", fire_a); end
    step();
    checks++; if (fire_a !== 1'b1) begin errors++; $display("[TB] FAIL single_fire: got %b expected 1", fire_a); end
    checks++; if (sel_a !== 2'd2) begin errors++; $display("[TB] FAIL single_sel: got %0d expected 2", sel_a); end
    checks++; if (grant_a !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant: got %b expected 0100", grant_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy_a); end
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_dn = (k == 4);
      checks++; if (dn_a !== exp_dn) begin errors++; $display("[TB] FAIL single_driveNext_c%0d: got %b expected %b", k, dn_a, exp_dn); end
    end
    checks++; if (free_a !== 4'b0) begin errors++; $display("[TB] FAIL single_free_early: got %b expected 0000", free_a); end
    free_next_a = 1'b1;
    step();
    free_next_a = 1'b0;
    checks++; if (free_a !== 4'b0100) begin errors++; $display("[TB] FAIL single_free: got %b expected 0100", free_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %b expected 0", busy_a); end
    checks++; if (grant_a !== 4'b0) begin errors++; $display("[TB] FAIL single_grant_end: got %b expected 0000", grant_a); end
    step();
    checks++; if (free_a !== 4'b0) begin errors++; $display("[TB] FAIL single_free_pulse: got %b expected 0000", free_a); end
  endtask

  // All four at once give order 0,1,2,3 back-to-back; then 1001 gives 0,3.
  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 0, 3};
    int c;
    $display("[TB] test_round_robin");
    do_reset();
    drive_a = 4'b1111;
    step();
    drive_a = '0;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        drive_a = 4'b1001;
        step();
        drive_a = '0;
      end
      c = 0;
      while (fire_a !== 1'b1 && c < 12) begin step(); c++; end
      checks++; if (fire_a !== 1'b1) begin errors++; $display("[TB] FAIL rr_fire_%0d: got %b expected 1 (timeout)", k, fire_a); end
      checks++; if (sel_a !== 2'(order[k])) begin errors++; $display("[TB] FAIL rr_sel_%0d: got %0d expected %0d", k, sel_a, order[k]); end
      c = 0;
      while (dn_a !== 1'b1 && c < 12) begin step(); c++; end
      checks++; if (c != 4) begin errors++; $display("[TB] FAIL rr_latency_%0d: got %0d cycles expected 4", k, c); end
      free_next_a = 1'b1;
      step();
      free_next_a = 1'b0;
      checks++; if (free_a !== 4'(1 << order[k])) begin errors++; $display("[TB] FAIL rr_free_%0d: got %b expected %b", k, free_a, 4'(1 << order[k])); end
      step();
      if (k < 3) begin
        checks++; if (fire_a !== 1'b1) begin errors++; $display("[TB] FAIL rr_back_to_back_%0d: got %b expected 1", k, fire_a); end
      end
    end
  endtask

  // Two extra tokens on pending branch 1: sticky overflow, a single free.
  task automatic test_overflow();
    int c;
    int n_free;
    int n_fire;
    $display("[TB] test_overflow");
    do_reset();
    drive_a = 4'b0010;
    step();
    drive_a = '0;
    step();
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b expected 0", ovf_a); end
    drive_a = 4'b0010;
    step();
    drive_a = '0;
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf_a); end
    drive_a = 4'b0010;
    step();
    drive_a = '0;
    c = 0;
    while (dn_a !== 1'b1 && c < 12) begin step(); c++; end
    checks++; if (dn_a !== 1'b1) begin errors++; $display("[TB] FAIL ovf_driveNext: got %b expected 1 (timeout)", dn_a); end
    free_next_a = 1'b1;
    step();
    free_next_a = 1'b0;
    checks++; if (free_a !== 4'b0010) begin errors++; $display("[TB] FAIL ovf_free: got %b expected 0010", free_a); end
    n_free = 0;
    n_fire = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (free_a !== 4'b0) n_free++;
      if (fire_a !== 1'b0) n_fire++;
    end
    checks++; if (n_free != 0) begin errors++; $display("[TB] FAIL ovf_extra_free: got %0d expected 0", n_free); end
    checks++; if (n_fire != 0) begin errors++; $display("[TB] FAIL ovf_extra_fire: got %0d expected 0", n_fire); end
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", ovf_a); end
    do_reset();
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL ovf_reset: got %b expected 0", ovf_a); end
  endtask

  // Downstream free while idle or counting down is ignored.
  task automatic test_early_free();
    $display("[TB] test_early_free");
    do_reset();
    free_next_a = 1'b1;
    step();
    free_next_a = 1'b0;
    step();
    checks++; if (free_a !== 4'b0) begin errors++; $display("[TB] FAIL early_idle_free: got %b expected 0000", free_a); end
    checks++; if (fire_a !== 1'b0) begin errors++; $display("[TB] FAIL early_idle_fire: got %b expected 0", fire_a); end
    drive_a = 4'b0001;
    step();
    drive_a = '0;
    step();
    checks++; if (fire_a !== 1'b1) begin errors++; $display("[TB] FAIL early_fire: got %b expected 1", fire_a); end
    step();
    free_next_a = 1'b1;
    step();
    free_next_a = 1'b0;
    checks++; if (free_a !== 4'b0) begin errors++; $display("[TB] FAIL early_delay_free: got %b expected 0000", free_a); end
    step();
    checks++; if (dn_a !== 1'b0) begin errors++; $display("[TB] FAIL early_driveNext_c3: got %b expected 0", dn_a); end
    step();
    checks++; if (dn_a !== 1'b1) begin errors++; $display("[TB] FAIL early_driveNext_c4: got %b expected 1", dn_a); end
    step();
    step();
    checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL early_still_busy: got %b expected 1", busy_a); end
    checks++; if (free_a !== 4'b0) begin errors++; $display("[TB] FAIL early_no_free: got %b expected 0000", free_a); end
    free_next_a = 1'b1;
    step();
    free_next_a = 1'b0;
    checks++; if (free_a !== 4'b0001) begin errors++; $display("[TB] FAIL early_free: got %b expected 0001", free_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL early_busy_end: got %b expected 0", busy_a); end
  endtask

  // Reset while waiting for free aborts silently and forgets pend and last.
  task automatic test_mid_reset();
    int c;
    int n_act;
    $display("[TB] test_mid_reset");
    do_reset();
    drive_a = 4'b0100;
    step();
    drive_a = '0;
    c = 0;
    while (dn_a !== 1'b1 && c < 12) begin step(); c++; end
    step();
    checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy_a); end
    rst = 1'b0;
    free_next_a = 1'b1;
    step();
    rst = 1'b1;
    free_next_a = 1'b0;
    checks++; if ({free_a, fire_a, sel_a, grant_a, dn_a, busy_a} !== 13'b0) begin errors++; $display("[TB] FAIL midrst_outputs: got %b expected all 0", {free_a, fire_a, sel_a, grant_a, dn_a, busy_a}); end
    n_act = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (fire_a !== 1'b0 || free_a !== 4'b0) n_act++;
    end
    checks++; if (n_act != 0) begin errors++; $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", n_act); end
    drive_a = 4'b1010;
    step();
    drive_a = '0;
    step();
    checks++; if (fire_a !== 1'b1) begin errors++; $display("[TB] FAIL midrst_fire: got %b expected 1", fire_a); end
    checks++; if (sel_a !== 2'd1) begin errors++; $display("[TB] FAIL midrst_sel: got %0d expected 1", sel_a); end
  endtask

  // DELAY=1 instance: driveNext one cycle after fire; re-drive on the free
  // cycle and on the o_free cycle keeps the branch pending behind the others.
  task automatic test_back_to_back();
    int         order    [5] = '{0, 1, 2, 0, 2};
    logic [3:0] at_free  [5] = '{4'b0110, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] at_ofree [5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    int c;
    int n_fire;
    $display("[TB] test_back_to_back");
    do_reset();
    drive_b = 4'b0001;
    step();
    drive_b = '0;
    for (int k = 0; k < 5; k++) begin
      c = 0;
      while (fire_b !== 1'b1 && c < 12) begin step(); c++; end
      checks++; if (fire_b !== 1'b1) begin errors++; $display("[TB] FAIL b2b_fire_%0d: got %b expected 1 (timeout)", k, fire_b); end
      checks++; if (sel_b !== 2'(order[k])) begin errors++; $display("[TB] FAIL b2b_sel_%0d: got %0d expected %0d", k, sel_b, order[k]); end
      c = 0;
      while (dn_b !== 1'b1 && c < 12) begin step(); c++; end
      checks++; if (c != 1) begin errors++; $display("[TB] FAIL b2b_latency_%0d: got %0d cycles expected 1", k, c); end
      free_next_b = 1'b1;
      drive_b = at_free[k];
      step();
      free_next_b = 1'b0;
      drive_b = at_ofree[k];
      checks++; if (free_b !== 4'(1 << order[k])) begin errors++; $display("[TB] FAIL b2b_free_%0d: got %b expected %b", k, free_b, 4'(1 << order[k])); end
      step();
      drive_b = '0;
    end
    n_fire = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (fire_b !== 1'b0) n_fire++;
    end
    checks++; if (n_fire != 0) begin errors++; $display("[TB] FAIL b2b_drained: got %0d fires expected 0", n_fire); end
    checks++; if (ovf_b !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overflow: got %b expected 0", ovf_b); end
  endtask

  initial begin
    rst = 1'b0;
    drive_a = '0; drive_b = '0; free_next_a = 1'b0; free_next_b = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_early_free();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case a wait above is ever unbounded.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
